// File: rtl/gate_stim_checker.sv
// gate_stim_checker: on-chip stimulus generator and response checker for the
// Inv/And2 gate DUTs. Three Galois LFSRs drive in1..in3. The expected ~in1 and
// in1&in2 values are delayed by DUT_LAT stages and compared with the DUT
// responses. The block reports an error count, the first failing index, and
// pass/done.
module gate_stim_checker #(
  parameter int                 WIDTH   = 64,
  parameter int                 DUT_LAT = 0,
  parameter logic [WIDTH-1:0]   SEED1   = 64'h0123_4567_89AB_CDEF,
  parameter logic [WIDTH-1:0]   SEED2   = 64'hFEDC_BA98_7654_3210,
  parameter logic [WIDTH-1:0]   SEED3   = 64'h0F1E_2D3C_4B5A_6978
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      num_vec,
  output logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] in3,
  output logic             vec_valid,
  input  logic [WIDTH-1:0] dut_inv,
  input  logic [WIDTH-1:0] dut_and2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic             first_err_valid,
  output logic [31:0]      first_err_idx
);

  // Galois toggle mask for x^64 + x^63 + x^61 + x^60 + 1 (right-shifting form).
  localparam logic [WIDTH-1:0] POLY    = 64'hD800_0000_0000_0000;
  localparam int               MAX_LAT = 4;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // An all-zero state would lock the LFSR, so replace a zero seed with 1.
  function automatic logic [WIDTH-1:0] fix_seed(input logic [WIDTH-1:0] s);
    return (s == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : s;
  endfunction

  localparam logic [WIDTH-1:0] S1 = fix_seed(SEED1);
  localparam logic [WIDTH-1:0] S2 = fix_seed(SEED2);
  localparam logic [WIDTH-1:0] S3 = fix_seed(SEED3);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // One stage of the expected-value pipeline.
  typedef struct packed {
    logic             valid;
    logic [31:0]      idx;
    logic [WIDTH-1:0] inv;
    logic [WIDTH-1:0] and2;
  } stage_t;

  state_t      state;
  logic [31:0] vec_idx;
  logic [31:0] num_q;

  stage_t pipe [1:MAX_LAT];
  stage_t tap  [0:MAX_LAT];
  stage_t chk;

  logic        mismatch;
  logic        last_chk;
  logic [15:0] err_next;
  logic        fe_valid_next;
  logic [31:0] fe_idx_next;

  // Tap 0 is the live vector. Taps 1..MAX_LAT are the delayed copies.
  always_comb begin
    tap[0] = '{valid: vec_valid, idx: vec_idx, inv: ~in1, and2: in1 & in2};
    for (int i = 1; i <= MAX_LAT; i++) tap[i] = pipe[i];
  end

  assign chk      = tap[DUT_LAT];
  assign mismatch = busy && chk.valid && ((dut_inv != chk.inv) || (dut_and2 != chk.and2));
  assign last_chk = chk.valid && (chk.idx == num_q - 32'd1);

  // Next error count and first-error record for the check made at this edge.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    err_next      = err_count;
    fe_valid_next = first_err_valid;
    fe_idx_next   = first_err_idx;
    if (mismatch) begin
      if (err_count != 16'hFFFF) err_next = err_count + 16'd1;
      if (!first_err_valid) begin
        fe_valid_next = 1'b1;
        fe_idx_next   = chk.idx;
      end
    end
  end

  // Expected-value delay line: shifts every cycle and holds valid/index/expects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the delay line is reset so an aborted run cannot leave a stale
      // valid that would fire a check after the next launch.
      for (int i = 1; i <= MAX_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[1] <= tap[0];
      for (int i = 2; i <= MAX_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Control FSM: launch, vector sequencing, drain, and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples its pre-edge value regardless of statement order.
      state           <= IDLE;
      vec_idx         <= '0;
      num_q           <= '0;
      in1             <= '0;
      in2             <= '0;
      in3             <= '0;
      vec_valid       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            num_q           <= num_vec;
            vec_idx         <= '0;
            if (num_vec == 32'd0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state     <= RUN;
              done      <= 1'b0;
              pass      <= 1'b0;
              busy      <= 1'b1;
              vec_valid <= 1'b1;
              in1       <= S1;
              in2       <= S2;
              in3       <= S3;
            end
          end
        end

        RUN: begin
          err_count       <= err_next;
          first_err_valid <= fe_valid_next;
          first_err_idx   <= fe_idx_next;
          if (vec_idx == num_q - 32'd1) begin
            // The last vector has been presented, so in1..in3 hold their value.
            vec_valid <= 1'b0;
            if (DUT_LAT == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 16'd0);
            end else begin
              state <= DRAIN;
            end
          end else begin
            vec_idx <= vec_idx + 32'd1;
            in1     <= lfsr_step(in1);
            in2     <= lfsr_step(in2);
            in3     <= lfsr_step(in3);
          end
        end

        DRAIN: begin
          err_count       <= err_next;
          first_err_valid <= fe_valid_next;
          first_err_idx   <= fe_idx_next;
          if (last_chk) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 16'd0);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_stim_checker.md
Name: gate_stim_checker

Overview:
- On-chip counterpart to the software C-TB used for the gate tests: generates pseudo-random stimulus for the Inv/And2 gate DUTs and checks their outputs in hardware.
- Drives in1/in2/in3 from three 64-bit LFSRs and computes expected ~in1 and in1&in2.
- Compares expected values against DUT responses after a configurable DUT latency; reports error count, first failing vector index and pass/done.
- Sits beside the gate DUTs in a self-checking top, so a bench only needs to pulse start and read the result.

Parameters:
WIDTH, 64, data width of stimulus and responses (fixed 64; LFSR polynomial is defined for 64).
DUT_LAT, 0, DUT latency in cycles, legal 0..4.
SEED1, 64'h0123_4567_89AB_CDEF, in1 LFSR seed.
SEED2, 64'hFEDC_BA98_7654_3210, in2 LFSR seed.
SEED3, 64'h0F1E_2D3C_4B5A_6978, in3 LFSR seed.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  level; launches a run when sampled high in IDLE or DONE.
num_vec  in  32  vectors per run, sampled at launch.
in1  out  WIDTH  stimulus to DUT.
in2  out  WIDTH  stimulus to DUT.
in3  out  WIDTH  stimulus to DUT.
vec_valid  out  1  in1..in3 carry a live vector this cycle.
dut_inv  in  WIDTH  DUT inverter response.
dut_and2  in  WIDTH  DUT and2 response.
busy  out  1  run in progress (RUN or DRAIN).
done  out  1  run complete, held until next launch.
pass  out  1  valid when done; 1 iff err_count==0.
err_count  out  16  mismatching vectors, saturates at 16'hFFFF.
first_err_valid  out  1  at least one mismatch seen this run.
first_err_idx  out  32  index of first mismatching vector.

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0, including in1..in3. Asserting rst_n low mid-run aborts immediately. No partial result is kept.
- LFSRs: Galois, polynomial x^64+x^63+x^61+x^60+1. A zero seed is replaced by 64'h1. All three advance together, one step per RUN cycle.
- States: IDLE, RUN, DRAIN, DONE. busy=1 in RUN and DRAIN only.
- Launch from IDLE or DONE when start=1:
  - Clear err_count, first_err_*, done and pass.
  - Capture num_vec.
  - If num_vec==0, go to DONE with pass=1 and vec_valid stays 0.
  - Otherwise load in1/in2/in3 with the seeds, set vec_valid=1 and go to RUN. The registered outputs show vector 0 in the first RUN cycle.
- start is ignored in RUN and DRAIN.
- RUN:
  - Vector k is presented during RUN cycle k, for k = 0..num_vec-1.
  - At the edge ending cycle num_vec-1, vec_valid goes to 0, in1..in3 hold their last value, and the state moves to DRAIN. With DUT_LAT=0 it moves directly to DONE.
- Expected pipeline:
  - exp_inv = ~in1 and exp_and2 = in1&in2, delayed with valid and index by DUT_LAT registers.
  - With DUT_LAT=0 the comparison is against the same-cycle in1/in2.
  - The check of vector k samples dut_inv/dut_and2 at the edge ending cycle k+DUT_LAT.
  - in3 is driven but not checked (reserved for mux2).
- Mismatch: either output differing in any bit counts once per vector.
  - err_count increments, saturating at 16'hFFFF.
  - On the first mismatch, first_err_idx=k and first_err_valid=1. Later mismatches do not overwrite them.
- DRAIN: lasts until the last check (vector num_vec-1) completes, then DONE.
- DONE: entered at the edge ending cycle num_vec-1+DUT_LAT, counted from RUN cycle 0. From then done=1, pass=(err_count==0), and all results are held.
- Simultaneous last check and saturating err_count: stays at FFFF. Counter widths never wrap.

Test Plan:
- Correct comb DUT, DUT_LAT=0, num_vec=1000, start pulse → done rises 1000 cycles after the first vec_valid cycle; pass=1, err_count=0, first_err_valid=0.
- Correct DUT registered once, DUT_LAT=1, num_vec=16 → busy for 17 cycles; pass=1. Re-run the same bench with DUT_LAT=0 → err_count nonzero, which proves the alignment.
- dut_and2 bit5 forced 0, SEED1=SEED2=all ones, num_vec=100 → first_err_idx=0, first_err_valid=1; err_count equals a reference model count of vectors with in1[5]&in2[5]=1.
- num_vec=0 → DONE on the cycle after launch, pass=1, vec_valid never asserted. start held high in DONE → relaunch, results cleared.
- Permanently inverted dut_inv, num_vec=70000 → err_count saturates at FFFF, pass=0.
- rst_n pulsed low mid-RUN at vector 50 → all outputs 0 within the reset cycle; the next start produces vector 0 equal to the seeds again.
